// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared encodings for the memory port arbiter: FSM state codes,
//               memory access width codes (funct3[1:0] encoding) and the codes
//               reported on owner_o.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Access width codes
    localparam logic [1:0] MEM_BYTE  = 2'b00;
    localparam logic [1:0] MEM_HALF  = 2'b01;
    localparam logic [1:0] MEM_WORD  = 2'b10;

    // Port owner codes
    localparam logic       OWN_IF    = 1'b0;
    localparam logic       OWN_DM    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_streak_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_streak_ctr
// Description : Saturating count of consecutive data grants made while a
//               fetch was waiting, plus the compare against the limit.
// Ports       : clk        in  clock
//               rst        in  asynchronous active-high reset
//               i_inc      in  data grant issued while fetch is pending
//               i_clr      in  fetch grant issued
//               o_at_limit out count has reached LIMIT
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_streak_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam int c_CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(LIMIT);

    logic [c_CNT_W-1:0] r_count;

    // Saturates at LIMIT so a long data burst cannot wrap back below it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_limit = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between instruction fetch (IF)
//               and data access (DM). Each access runs IDLE -> ACCESS -> RESP
//               over a req/ack handshake with variable memory latency. Data
//               has priority over fetch.
// Config      : MEM_ARB_STARVE_GUARD_EN - when defined, after STARVE_LIMIT
//               consecutive DM grants with IF waiting, IF wins the next
//               contested arbitration. Undefined: strict DM priority.
// Ports       : clk_i, rst_i            clock / async active-high reset
//               if_req_i, if_addr_i     fetch request (held until if_ack_o)
//               if_ack_o, if_rdata_o    fetch response pulse / fetched word
//               dm_req_i, dm_we_i, dm_width_i, dm_addr_i, dm_wdata_i
//                                       data request (held until dm_ack_o)
//               dm_ack_o, dm_rdata_o    data response pulse / raw load word
//               mem_req_o, mem_we_o, mem_width_o, mem_addr_o, mem_wdata_o
//                                       memory request (held until mem_ack_i)
//               mem_ack_i, mem_rdata_i  memory completion / read data
//               owner_o                 0 = IF, 1 = DM (valid while busy_o)
//               busy_o                  FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [1:0]        dm_width_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [1:0]        mem_width_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              owner_o,
    output logic              busy_o
);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              w_in_idle;
    logic              w_force_if;
    logic              w_grant_dm;
    logic              w_grant_if;
    logic              w_mem_done;

    logic              r_owner;
    logic              r_we;
    logic [1:0]        r_width;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    // ------------------------------------------------------------------
    // Arbitration: only evaluated in IDLE; DM wins unless the starvation
    // guard forces the fetch through.
    // ------------------------------------------------------------------
    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_grant_dm = w_in_idle && dm_req_i && !w_force_if;
    assign w_grant_if = w_in_idle && if_req_i && !w_grant_dm;
    // mem_ack_i outside ACCESS is a stray pulse and must not complete anything.
    assign w_mem_done = (r_state == ST_ACCESS) && mem_ack_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic w_at_limit;

    mem_arb_streak_ctr #(
        .LIMIT      (STARVE_LIMIT)
    ) u_streak_ctr (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_inc      (w_grant_dm && if_req_i),
        .i_clr      (w_grant_if),
        .o_at_limit (w_at_limit)
    );

    assign w_force_if = w_at_limit && if_req_i && dm_req_i;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (STARVE_LIMIT != 0);
    assign w_force_if   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (dm_req_i || if_req_i) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack_i) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Decoding from state means an asynchronous reset drops
    // mem_req_o and busy_o the instant rst_i rises.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_o = 1'b0;
        if_ack_o  = 1'b0;
        dm_ack_o  = 1'b0;
        busy_o    = (r_state != ST_IDLE);
        case (r_state)
            ST_ACCESS: begin
                mem_req_o = 1'b1;
            end
            ST_RESP: begin
                if_ack_o = (r_owner == OWN_IF);
                dm_ack_o = (r_owner == OWN_DM);
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Granted request fields and response data
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_owner    <= OWN_IF;
            r_we       <= 1'b0;
            r_width    <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (w_grant_dm) begin
                r_owner <= OWN_DM;
                r_we    <= dm_we_i;
                r_width <= dm_width_i;
                r_addr  <= dm_addr_i;
                r_wdata <= dm_wdata_i;
            end else if (w_grant_if) begin
                // Fetches are always word reads.
                r_owner <= OWN_IF;
                r_we    <= 1'b0;
                r_width <= MEM_WORD;
                r_addr  <= if_addr_i;
                r_wdata <= '0;
            end

            if (w_mem_done) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= mem_rdata_i;
                end else if (!r_we) begin
                    // Stores leave the last load word untouched.
                    r_dm_rdata <= mem_rdata_i;
                end
            end
        end
    end

    assign mem_we_o    = r_we;
    assign mem_width_o = r_width;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign owner_o     = r_owner;
    assign if_rdata_o  = r_if_rdata;
    assign dm_rdata_o  = r_dm_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Randomized scoreboard bench for mem_port_arbiter. A driver
//               process plays both requesters and the memory, and a reference
//               model decides which request each free arbitration slot should
//               serve, queuing the expected memory request and response. A
//               monitor pops and compares whenever the DUT presents a memory
//               request or an ack. Directed phases cover reset mid-access and
//               fetch starvation. Honours MEM_ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic        we;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        owner;
        int          cyc;
    } mem_exp_t;

    typedef struct {
        logic        is_if;
        logic [31:0] if_rd;
        logic [31:0] dm_rd;
        int          cyc;
    } ack_exp_t;

    logic        clk_i       = 1'b0;
    logic        rst_i       = 1'b1;
    logic        if_req_i    = 1'b0;
    logic [31:0] if_addr_i   = '0;
    logic        dm_req_i    = 1'b0;
    logic        dm_we_i     = 1'b0;
    logic [1:0]  dm_width_i  = 2'b00;
    logic [31:0] dm_addr_i   = '0;
    logic [31:0] dm_wdata_i  = '0;
    logic        mem_ack_i   = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o, owner_o, busy_o;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic [1:0]  mem_width_o;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_ack_o    (if_ack_o),
        .if_rdata_o  (if_rdata_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_width_i  (dm_width_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_ack_o    (dm_ack_o),
        .dm_rdata_o  (dm_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_width_o (mem_width_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .owner_o     (owner_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard and bookkeeping
    mem_exp_t exp_mem_q[$];
    ack_exp_t exp_ack_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int if_done = 0;
    int dm_done = 0;
    int if_grants = 0;
    int dm_grants = 0;

    // Stimulus controls
    bit rand_en   = 1'b0;
    bit if_kick   = 1'b0;
    bit dm_kick   = 1'b0;
    bit dm_cont   = 1'b0;
    bit mem_stall = 1'b0;

    // Reference model state
    bit          mdl_busy  = 1'b0;
    int          mdl_free  = 0;
    logic        mdl_owner = 1'b0;
    logic        mdl_store = 1'b0;
    logic [31:0] last_if   = '0;
    logic [31:0] last_dm   = '0;
    int          mem_wait  = -1;
`ifdef MEM_ARB_STARVE_GUARD_EN
    int          mdl_streak = 0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: requesters, memory responder and reference model, all acting
    // just after each rising edge.
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
            #1;
            if (rst_i) begin
                if_req_i  = 1'b0;
                dm_req_i  = 1'b0;
                mem_ack_i = 1'b0;
                mem_wait  = -1;
                mdl_busy  = 1'b0;
                mdl_free  = 0;
                last_if   = '0;
                last_dm   = '0;
                exp_mem_q.delete();
                exp_ack_q.delete();
`ifdef MEM_ARB_STARVE_GUARD_EN
                mdl_streak = 0;
`endif
            end else begin
                // Fetch requester
                if (if_req_i && if_ack_o) begin
                    if_req_i = 1'b0;
                end else if (!if_req_i && (if_kick || (rand_en && $urandom_range(0, 3) == 0))) begin
                    if_req_i  = 1'b1;
                    if_addr_i = $urandom & 32'hFFFF_FFFC;
                    if_kick   = 1'b0;
                end
                // Data requester
                if (dm_req_i && dm_ack_o) begin
                    dm_req_i = 1'b0;
                end else if (!dm_req_i && (dm_kick || dm_cont || (rand_en && $urandom_range(0, 3) == 0))) begin
                    dm_req_i   = 1'b1;
                    dm_we_i    = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 2))
                        0:       dm_width_i = MEM_BYTE;
                        1:       dm_width_i = MEM_HALF;
                        default: dm_width_i = MEM_WORD;
                    endcase
                    dm_addr_i  = $urandom;
                    dm_wdata_i = $urandom;
                    dm_kick    = 1'b0;
                end
                // Memory: 0..2 cycles of wait, plus stray acks while idle
                mem_ack_i = 1'b0;
                if (mem_req_o && !mem_stall) begin
                    if (mem_wait < 0) mem_wait = $urandom_range(0, 2);
                    if (mem_wait == 0) begin
                        ack_exp_t a;
                        mem_ack_i   = 1'b1;
                        mem_rdata_i = $urandom;
                        mem_wait    = -1;
                        if (mdl_owner == OWN_IF) last_if = mem_rdata_i;
                        else if (!mdl_store)     last_dm = mem_rdata_i;
                        a.is_if = (mdl_owner == OWN_IF);
                        a.if_rd = last_if;
                        a.dm_rd = last_dm;
                        a.cyc   = cyc + 1;
                        exp_ack_q.push_back(a);
                        mdl_busy = 1'b0;
                        mdl_free = cyc + 2;
                    end else begin
                        mem_wait--;
                    end
                end else if (!mem_req_o && rand_en && $urandom_range(0, 7) == 0) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = $urandom;
                end
                // Reference model: a free port serves DM first, IF otherwise
                if (!mdl_busy && cyc >= mdl_free && (if_req_i || dm_req_i)) begin
                    mem_exp_t e;
                    bit pick_if;
                    pick_if = !dm_req_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
                    if (if_req_i && dm_req_i && mdl_streak == STARVE_LIMIT) pick_if = 1'b1;
`endif
                    if (pick_if) begin
                        e.we = 1'b0; e.width = MEM_WORD; e.addr = if_addr_i;
                        e.wdata = '0; e.owner = OWN_IF;
`ifdef MEM_ARB_STARVE_GUARD_EN
                        mdl_streak = 0;
`endif
                    end else begin
                        e.we = dm_we_i; e.width = dm_width_i; e.addr = dm_addr_i;
                        e.wdata = dm_wdata_i; e.owner = OWN_DM;
`ifdef MEM_ARB_STARVE_GUARD_EN
                        if (if_req_i && mdl_streak < STARVE_LIMIT) mdl_streak++;
`endif
                    end
                    e.cyc = cyc + 1;
                    exp_mem_q.push_back(e);
                    mdl_busy  = 1'b1;
                    mdl_owner = e.owner;
                    mdl_store = e.we;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares at each falling edge
    // ------------------------------------------------------------------
    initial begin
        mem_exp_t cur;
        ack_exp_t a;
        logic prev_req;
        prev_req = 1'b0;
        cur = '{we: 1'b0, width: 2'b00, addr: '0, wdata: '0, owner: 1'b0, cyc: 0};
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_req = 1'b0;
            end else begin
                if (mem_req_o && !prev_req) begin
                    if (exp_mem_q.size() == 0) begin
                        chk("unexpected_mem_req", 1'b1, 1'b0);
                    end else begin
                        cur = exp_mem_q.pop_front();
                        chk("mem_req_cycle", 64'(cyc), 64'(cur.cyc));
                        if (owner_o) dm_grants++; else if_grants++;
                    end
                end
                if (mem_req_o) begin
                    chk("mem_fields",
                        {owner_o, mem_we_o, mem_width_o, mem_addr_o, (owner_o ? mem_wdata_o : 32'h0)},
                        {cur.owner, cur.we, cur.width, cur.addr, cur.wdata});
                end
                prev_req = mem_req_o;
                if (if_ack_o || dm_ack_o) begin
                    if (exp_ack_q.size() == 0) begin
                        chk("unexpected_ack", {if_ack_o, dm_ack_o}, 2'b00);
                    end else begin
                        a = exp_ack_q.pop_front();
                        chk("ack_port", {if_ack_o, dm_ack_o}, a.is_if ? 2'b10 : 2'b01);
                        chk("ack_cycle", 64'(cyc), 64'(a.cyc));
                        chk("if_rdata", if_rdata_o, a.if_rd);
                        chk("dm_rdata", dm_rdata_o, a.dm_rd);
                        if (a.is_if) if_done++; else dm_done++;
                    end
                end
            end
        end
    end

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk_i);
            ok = !if_req_i && !dm_req_i && !busy_o && !if_kick && !dm_kick
                 && exp_mem_q.size() == 0 && exp_ack_q.size() == 0;
        end
        chk("drain_idle", ok, 1'b1);
    endtask

    task automatic summary_and_finish();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    initial begin
        int snap_if, snap_dm;
        bit seen;

        // Reset state
        repeat (2) @(posedge clk_i);
        #2;
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_acks", {if_ack_o, dm_ack_o}, 2'b00);
        chk("rst_owner", owner_o, 1'b0);
        chk("rst_mem_fields", {mem_we_o, mem_width_o, mem_addr_o, mem_wdata_o}, '0);
        chk("rst_rdata", {if_rdata_o, dm_rdata_o}, '0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Random traffic, latencies and stray memory acks
        rand_en = 1'b1;
        repeat (3000) @(posedge clk_i);
        rand_en = 1'b0;
        drain();

        // Reset in the middle of an access
        mem_stall = 1'b1;
        dm_kick   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            seen = mem_req_o;
        end
        chk("abort_mem_req_seen", seen, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        chk("abort_mem_req", mem_req_o, 1'b0);
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_acks", {if_ack_o, dm_ack_o}, 2'b00);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i     = 1'b0;
        mem_stall = 1'b0;
        chk("abort_rdata", {if_rdata_o, dm_rdata_o}, '0);

        // Fetch waiting against a continuously re-requesting data port
        snap_if = if_grants;
        snap_dm = dm_grants;
        if_kick = 1'b1;
        dm_cont = 1'b1;
`ifdef MEM_ARB_STARVE_GUARD_EN
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            seen = (if_grants != snap_if);
        end
        chk("starve_if_granted", seen, 1'b1);
        chk("starve_dm_before_if", 64'(dm_grants - snap_dm), 64'(STARVE_LIMIT));
`else
        repeat (60) @(negedge clk_i);
        chk("starve_if_grants", 64'(if_grants - snap_if), 64'd0);
        chk("starve_dm_progress", (dm_grants - snap_dm) >= 5, 1'b1);
`endif
        dm_cont = 1'b0;
        drain();

        // More random traffic after the reset
        rand_en = 1'b1;
        repeat (1000) @(posedge clk_i);
        rand_en = 1'b0;
        drain();

        chk("if_activity", if_done > 50, 1'b1);
        chk("dm_activity", dm_done > 50, 1'b1);
        summary_and_finish();
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL global_timeout: actual running required finished");
        summary_and_finish();
    end

endmodule
`default_nettype wire
